// File: rtl/m_instruction_fetch_unit_pkg.sv
// Shared opcode constants, FSM encoding and decode helpers
// for the 8-bit instruction fetch unit.
package m_instruction_fetch_unit_pkg;

  localparam logic [3:0] OP_JAL    = 4'b1010;
  localparam logic [3:0] OP_BFS    = 4'b1001;
  localparam logic [3:0] NIB_MOV   = 4'b1111;
  localparam logic [7:0] WORD_HALT = 8'h00;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;

  // Low nibble 1111 turns either opcode into a mov.
  function automatic logic is_jal(input logic [7:0] w);
    return (w[7:4] == OP_JAL) && (w[3:0] != NIB_MOV);
  endfunction

  function automatic logic is_bfs(input logic [7:0] w);
    return (w[7:4] == OP_BFS) && (w[3:0] != NIB_MOV);
  endfunction

endpackage

// File: rtl/m_instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory, ALU feedback
// and execute-side outputs.
interface m_instruction_fetch_unit_if;

  logic [7:0] w_bus_imem_rdata;
  logic       w_imem_valid;
  logic [7:0] w_bus_alu_out;
  logic       w_cf;
  logic       w_stall;
  logic [7:0] w_bus_pc;
  logic       w_imem_req;
  logic [7:0] w_bus_word;
  logic       w_word_valid;
  logic [7:0] w_bus_link;
  logic       w_link_we;
  logic       w_halted;

  modport master (
    input  w_bus_imem_rdata,
    input  w_imem_valid,
    input  w_bus_alu_out,
    input  w_cf,
    input  w_stall,
    output w_bus_pc,
    output w_imem_req,
    output w_bus_word,
    output w_word_valid,
    output w_bus_link,
    output w_link_we,
    output w_halted
  );

  modport slave (
    output w_bus_imem_rdata,
    output w_imem_valid,
    output w_bus_alu_out,
    output w_cf,
    output w_stall,
    input  w_bus_pc,
    input  w_imem_req,
    input  w_bus_word,
    input  w_word_valid,
    input  w_bus_link,
    input  w_link_we,
    input  w_halted
  );

endinterface

// File: rtl/m_8bit_plus1_adder.sv
// 8-bit incrementer with natural wrap (FF -> 00).
module m_8bit_plus1_adder (
  input  logic [7:0] w_bus_a,
  output logic [7:0] w_bus_sum
);

  assign w_bus_sum = w_bus_a + 8'd1;

endmodule

// File: rtl/m_instruction_fetch_unit.sv
// Two-cycle fetch/execute sequencer: FETCH waits for memory,
// EXEC holds the word until the exit cycle updates the PC.
module m_instruction_fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input logic                         w_clock,
  input logic                         w_reset_n,
  m_instruction_fetch_unit_if.master  bus
);

  import m_instruction_fetch_unit_pkg::*;

  fetch_state_t state;
  logic [7:0]   pc;
  logic [7:0]   ir;
  logic [7:0]   pc_plus1;
  logic [7:0]   next_pc;
  logic         in_fetch;
  logic         in_exec;
  logic         exit_cyc;
  logic         jal_hit;
  logic         bfs_hit;

  m_8bit_plus1_adder u_plus1 (
    .w_bus_a   (pc),
    .w_bus_sum (pc_plus1)
  );

  assign in_fetch = (state == S_FETCH);
  assign in_exec  = (state == S_EXEC);
  assign exit_cyc = in_exec && !bus.w_stall;
  assign jal_hit  = is_jal(ir);
  assign bfs_hit  = is_bfs(ir);

  always_comb begin
    next_pc = pc_plus1;
    unique case (1'b1)
      jal_hit:               next_pc = bus.w_bus_alu_out;
      bfs_hit && bus.w_cf:   next_pc = bus.w_bus_alu_out;
      default:               next_pc = pc_plus1;
    endcase
  end

  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= WORD_HALT;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (bus.w_imem_valid) begin
            ir    <= bus.w_bus_imem_rdata;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!bus.w_stall) begin
            // The halt word parks the PC on itself.
            if (ir == WORD_HALT) begin
              state <= S_HALT;
            end else begin
              pc    <= next_pc;
              state <= S_FETCH;
            end
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Request is gated by reset so it drops the instant reset asserts.
  assign bus.w_imem_req   = in_fetch && w_reset_n;
  assign bus.w_bus_pc     = pc;
  assign bus.w_bus_word   = ir;
  assign bus.w_word_valid = in_exec;
  assign bus.w_halted     = (state == S_HALT);
  assign bus.w_link_we    = exit_cyc && jal_hit;
  assign bus.w_bus_link   = bus.w_link_we ? pc_plus1 : 8'h00;

endmodule

// File: tb/tb_m_instruction_fetch_unit.sv
// Directed plus randomized checks of the fetch unit against an
// instruction-level reference model.
module tb_m_instruction_fetch_unit;

  localparam logic [7:0] RST_PC = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_pc = RST_PC;

  m_instruction_fetch_unit_if bus();

  m_instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .w_clock   (clk),
    .w_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] inc8(input logic [7:0] v);
    int n;
    n = (int'(v) + 1) % 256;
    return n[7:0];
  endfunction

  // Architectural rule: taken jal/bfs go to the ALU target, else PC+1.
  function automatic logic [7:0] ref_next_pc(input logic [7:0] pc,
      input logic [7:0] w, input logic cf, input logic [7:0] alu);
    logic mov;
    mov = (w[3:0] == 4'hF);
    if (!mov && w[7:4] == 4'hA) return alu;
    if (!mov && w[7:4] == 4'h9 && cf) return alu;
    return inc8(pc);
  endfunction

  task automatic run_insn(input logic [7:0] w, input int lat,
      input int stl, input logic cf, input logic [7:0] alu);
    logic jal;
    jal = (w[7:4] == 4'hA) && (w[3:0] != 4'hF);
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      check("fetch_req", bus.w_imem_req, 8'd1);
      check("fetch_pc", bus.w_bus_pc, exp_pc);
      check("fetch_word_valid", bus.w_word_valid, 8'd0);
      bus.w_stall = 1'b0;
      bus.w_imem_valid = (i == lat);
      bus.w_bus_imem_rdata = (i == lat) ? w : 8'($urandom);
    end
    for (int i = 0; i <= stl; i++) begin
      @(negedge clk);
      bus.w_imem_valid = 1'($urandom);
      bus.w_bus_imem_rdata = 8'($urandom);
      bus.w_stall = (i < stl);
      bus.w_cf = (i < stl) ? 1'($urandom) : cf;
      bus.w_bus_alu_out = (i < stl) ? 8'($urandom) : alu;
      #1;
      check("exec_word", bus.w_bus_word, w);
      check("exec_word_valid", bus.w_word_valid, 8'd1);
      check("exec_req", bus.w_imem_req, 8'd0);
      check("exec_halted", bus.w_halted, 8'd0);
      check("exec_pc", bus.w_bus_pc, exp_pc);
      check("exec_link_we", bus.w_link_we, 8'((i == stl) && jal));
      if ((i == stl) && jal)
        check("exec_link", bus.w_bus_link, inc8(exp_pc));
    end
    if (w != 8'h00) exp_pc = ref_next_pc(exp_pc, w, cf, alu);
  endtask

  task automatic reset_pulse();
    #1 rst_n = 1'b0;
    #1;
    check("rst_req", bus.w_imem_req, 8'd0);
    check("rst_pc", bus.w_bus_pc, RST_PC);
    check("rst_word_valid", bus.w_word_valid, 8'd0);
    check("rst_link_we", bus.w_link_we, 8'd0);
    check("rst_halted", bus.w_halted, 8'd0);
    check("rst_link", bus.w_bus_link, 8'd0);
    check("rst_word", bus.w_bus_word, 8'd0);
    bus.w_imem_valid = 1'b1;
    bus.w_bus_imem_rdata = 8'h77;
    bus.w_stall = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_word_hold", bus.w_bus_word, 8'd0);
    bus.w_imem_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_req", bus.w_imem_req, 8'd1);
    check("post_rst_pc", bus.w_bus_pc, RST_PC);
    exp_pc = RST_PC;
  endtask

  initial begin
    logic [7:0] w;
    bus.w_bus_imem_rdata = 8'h00;
    bus.w_imem_valid = 1'b0;
    bus.w_bus_alu_out = 8'h00;
    bus.w_cf = 1'b0;
    bus.w_stall = 1'b0;

    @(negedge clk);
    reset_pulse();

    run_insn(8'h40, 0, 0, 1'b0, 8'h9C);
    run_insn(8'h41, 0, 0, 1'b1, 8'h33);
    run_insn(8'h42, 0, 0, 1'b0, 8'h44);
    run_insn(8'h43, 0, 0, 1'b1, 8'h55);
    run_insn(8'h44, 0, 0, 1'b0, 8'h66);
    run_insn(8'hA3, 0, 0, 1'b0, 8'h20);
    run_insn(8'hAF, 0, 0, 1'b1, 8'h77);
    run_insn(8'h91, 0, 0, 1'b1, 8'h30);
    run_insn(8'h91, 0, 0, 1'b0, 8'h30);
    run_insn(8'hA0, 0, 1, 1'b0, 8'hFF);
    run_insn(8'h55, 0, 0, 1'b1, 8'h12);
    run_insn(8'h12, 3, 0, 1'b0, 8'h34);
    run_insn(8'h13, 0, 2, 1'b1, 8'h56);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0: w = {4'hA, 4'($urandom_range(0, 14))};
        1: w = {4'h9, 4'($urandom_range(0, 14))};
        2: w = ($urandom_range(0, 1) != 0) ? 8'hAF : 8'h9F;
        default: w = 8'($urandom_range(1, 255));
      endcase
      run_insn(w, $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom), 8'($urandom));
    end

    // Reset during the EXEC exit cycle of a jal.
    @(negedge clk);
    bus.w_imem_valid = 1'b1;
    bus.w_bus_imem_rdata = 8'hA5;
    bus.w_stall = 1'b0;
    @(negedge clk);
    bus.w_imem_valid = 1'b0;
    bus.w_bus_alu_out = 8'h99;
    bus.w_cf = 1'b1;
    #1;
    check("midexec_word_valid", bus.w_word_valid, 8'd1);
    reset_pulse();
    run_insn(8'h40, 0, 0, 1'b0, 8'h11);

    run_insn(8'h00, 1, 1, 1'b1, 8'h88);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("halt_halted", bus.w_halted, 8'd1);
      check("halt_req", bus.w_imem_req, 8'd0);
      check("halt_word_valid", bus.w_word_valid, 8'd0);
      check("halt_link_we", bus.w_link_we, 8'd0);
      check("halt_pc", bus.w_bus_pc, exp_pc);
      bus.w_imem_valid = 1'($urandom);
      bus.w_bus_imem_rdata = 8'($urandom);
      bus.w_stall = 1'($urandom);
    end
    bus.w_stall = 1'b0;
    reset_pulse();
    check("unhalt_halted", bus.w_halted, 8'd0);

    run_insn(8'h61, 0, 0, 1'b0, 8'h22);
    @(negedge clk);
    check("midfetch_req", bus.w_imem_req, 8'd1);
    check("midfetch_pc", bus.w_bus_pc, exp_pc);
    bus.w_imem_valid = 1'b1;
    bus.w_bus_imem_rdata = 8'h62;
    reset_pulse();
    run_insn(8'h40, 0, 0, 1'b0, 8'h00);
    @(negedge clk);
    check("final_pc", bus.w_bus_pc, exp_pc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
